// File: rtl/led_display_pkg.sv
// Shared display types: column count and the top/bottom half-row colour planes.
package led_display_pkg;

    localparam int GL_NUM_COL_PIXELS = 64;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    localparam int GL_RGB_ROW_W = $bits(rgb_row_t);

endpackage

// File: rtl/led_display_col_shifter.sv
// Column shifter: walks a captured row out MSB column first, one sclk period per
// column, and flags the end of the last column's high phase.
module led_display_col_shifter
    import led_display_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       start_in,
    input  rgb_row_t   row_in,
    output logic       sclk_out,
    output logic [2:0] rgb_top_out,
    output logic [2:0] rgb_bot_out,
    output logic       done_out
);

    // Phase counter spans one full column (low phase then high phase).
    localparam int PHASE_W = $clog2(2 * SCLK_DIV);
    localparam int BIT_W   = $clog2(GL_NUM_COL_PIXELS);

    localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(SCLK_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_FIRST  = BIT_W'(GL_NUM_COL_PIXELS - 1);

    logic               active_q, active_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic [2:0]         rgb_top_q, rgb_top_d;
    logic [2:0]         rgb_bot_q, rgb_bot_d;

    function automatic logic [2:0] pick(input rgb_half_t half, input logic [BIT_W-1:0] idx);
        return {half.blue[idx], half.green[idx], half.red[idx]};
    endfunction

    // Next column data is loaded only at the start of a low phase; sclk rises mid-column.
    always_comb begin
        active_d  = active_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        rgb_top_d = rgb_top_q;
        rgb_bot_d = rgb_bot_q;
        if (start_in) begin
            active_d  = 1'b1;
            phase_d   = '0;
            bit_d     = BIT_FIRST;
            sclk_d    = 1'b0;
            rgb_top_d = pick(row_in.top, BIT_FIRST);
            rgb_bot_d = pick(row_in.bot, BIT_FIRST);
        end else if (active_q) begin
            if (phase_q == PHASE_LAST) begin
                phase_d = '0;
                sclk_d  = 1'b0;
                if (bit_q == '0) begin
                    active_d  = 1'b0;
                    rgb_top_d = 3'b000;
                    rgb_bot_d = 3'b000;
                end else begin
                    bit_d     = bit_q - BIT_W'(1);
                    rgb_top_d = pick(row_in.top, bit_d);
                    rgb_bot_d = pick(row_in.bot, bit_d);
                end
            end else begin
                phase_d = phase_q + PHASE_W'(1);
                if (phase_q == PHASE_HIGH) begin
                    sclk_d = 1'b1;
                end
            end
        end
    end

    // Shifter state and pin registers; reset leaves the pins quiet.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            active_q  <= 1'b0;
            phase_q   <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            rgb_top_q <= 3'b000;
            rgb_bot_q <= 3'b000;
        end else begin
            active_q  <= active_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            rgb_top_q <= rgb_top_d;
            rgb_bot_q <= rgb_bot_d;
        end
    end

    assign sclk_out    = sclk_q;
    assign rgb_top_out = rgb_top_q;
    assign rgb_bot_out = rgb_bot_q;
    assign done_out    = active_q && (phase_q == PHASE_LAST) && (bit_q == '0);

endmodule

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: accepts a row, shifts it out, then blank/latch/display
// before accepting the next one.
module led_display_row_driver
    import led_display_pkg::*;
#(
    parameter int SCLK_DIV     = 2,
    parameter int LATCH_CYCLES = 2,
    parameter int OE_CYCLES    = 1000
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  rgb_row_t   row_in,
    input  logic       row_valid_in,
    output logic       row_ready_out,
    input  logic [3:0] row_address_in,
    output logic       sclk_out,
    output logic [2:0] rgb_top_out,
    output logic [2:0] rgb_bot_out,
    output logic       latch_out,
    output logic       n_oe_out,
    output logic [3:0] addr_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    // One counter serves both the latch pulse and the display window.
    localparam int HOLD_MAX = (LATCH_CYCLES > OE_CYCLES) ? LATCH_CYCLES : OE_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [HOLD_W-1:0] LATCH_LAST = HOLD_W'(LATCH_CYCLES - 1);
    localparam logic [HOLD_W-1:0] OE_LAST    = HOLD_W'(OE_CYCLES - 1);

    state_t            state_q, state_d;
    rgb_row_t          row_q, row_d;
    logic [3:0]        pend_addr_q, pend_addr_d;
    logic [3:0]        addr_q, addr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              start_q, start_d;
    logic              ready_q, ready_d;
    logic              latch_q, latch_d;
    logic              n_oe_q, n_oe_d;
    logic              shift_done;

    led_display_col_shifter #(
        .SCLK_DIV(SCLK_DIV)
    ) u_col_shifter (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .start_in   (start_q),
        .row_in     (row_q),
        .sclk_out   (sclk_out),
        .rgb_top_out(rgb_top_out),
        .rgb_bot_out(rgb_bot_out),
        .done_out   (shift_done)
    );

    // Row sequencing: capture, shift, blank with new address, latch, display.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        pend_addr_d = pend_addr_q;
        addr_d      = addr_q;
        hold_d      = hold_q;
        start_d     = 1'b0;
        ready_d     = ready_q;
        latch_d     = latch_q;
        n_oe_d      = n_oe_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (row_valid_in && ready_q) begin
                    row_d       = row_in;
                    pend_addr_d = row_address_in;
                    start_d     = 1'b1;
                    ready_d     = 1'b0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    addr_d  = pend_addr_q;
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                latch_d = 1'b1;
                hold_d  = '0;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (hold_q == LATCH_LAST) begin
                    latch_d = 1'b0;
                    n_oe_d  = 1'b0;
                    hold_d  = '0;
                    state_d = ST_DISPLAY;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_DISPLAY: begin
                if (hold_q == OE_LAST) begin
                    n_oe_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset drops any captured row and blanks the panel.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            pend_addr_q <= 4'd0;
            addr_q      <= 4'd0;
            hold_q      <= '0;
            start_q     <= 1'b0;
            ready_q     <= 1'b0;
            latch_q     <= 1'b0;
            n_oe_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pend_addr_q <= pend_addr_d;
            addr_q      <= addr_d;
            hold_q      <= hold_d;
            start_q     <= start_d;
            ready_q     <= ready_d;
            latch_q     <= latch_d;
            n_oe_q      <= n_oe_d;
        end
    end

    assign row_ready_out = ready_q;
    assign latch_out     = latch_q;
    assign n_oe_out      = n_oe_q;
    assign addr_out      = addr_q;

endmodule
